// File: rtl/mvm_arb_pkg.sv
// rtl/mvm_arb_pkg.sv - shared constants and state type for mvm_job_arbiter
package mvm_arb_pkg;

  localparam int WIDTH_DEF  = 12;
  localparam int X_SIZE_DEF = 8;
  localparam int W_SIZE_DEF = 64;

  localparam int JOB_WORDS_MAT = W_SIZE_DEF + X_SIZE_DEF;
  localparam int JOB_WORDS_VEC = X_SIZE_DEF;
  localparam int NUM_RESULTS   = X_SIZE_DEF;

  localparam logic [1:0] MAT_NONE = 2'd0;
  localparam logic [1:0] MAT_C0   = 2'd1;
  localparam logic [1:0] MAT_C1   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick, favouring the client not served last
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_idx,
  output logic       any_req
);

  assign any_req = |req;
  assign gnt_idx = (&req) ? ~last_grant : req[1];

endmodule

// File: rtl/mvm_job_arbiter.sv
// rtl/mvm_job_arbiter.sv - shares one matrix-vector engine between two job clients
// Grant is latched in IDLE; LOAD/DRAIN are pure combinational passthroughs.
module mvm_job_arbiter
  import mvm_arb_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int X_SIZE = X_SIZE_DEF,
  parameter int W_SIZE = W_SIZE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         in_valid,
  output logic [1:0]         in_ready,
  input  logic [2*WIDTH-1:0] in_data,
  input  logic [1:0]         in_new_matrix,
  output logic [1:0]         out_valid,
  input  logic [1:0]         out_ready,
  output logic [2*WIDTH-1:0] out_data,
  output logic               eng_rst,
  output logic               eng_input_valid,
  input  logic               eng_input_ready,
  output logic [WIDTH-1:0]   eng_input_data,
  output logic               eng_new_matrix,
  input  logic               eng_output_valid,
  output logic               eng_output_ready,
  input  logic [2*WIDTH-1:0] eng_output_data,
  output logic               grant,
  output logic               busy,
  output logic [1:0]         mat_owner
);

  localparam logic [6:0] LEN_MAT  = 7'(W_SIZE + X_SIZE);
  localparam logic [6:0] LEN_VEC  = 7'(X_SIZE);
  localparam logic [6:0] LAST_RES = 7'(X_SIZE - 1);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  logic [1:0] mat_owner_q, mat_owner_d;
  logic [6:0] cnt_q, cnt_d;
  logic [6:0] len_q, len_d;
  logic [6:0] len_cur;
  logic       gnt_idx, any_req;
  logic       in_acc, out_acc;

  rr_arb2 u_rr_arb2 (
    .req        (in_valid),
    .last_grant (last_grant_q),
    .gnt_idx    (gnt_idx),
    .any_req    (any_req)
  );

  always_comb begin
    in_ready         = 2'b00;
    out_valid        = 2'b00;
    eng_input_valid  = 1'b0;
    eng_new_matrix   = 1'b0;
    eng_output_ready = 1'b0;
    eng_input_data   = grant_q ? in_data[2*WIDTH-1:WIDTH] : in_data[WIDTH-1:0];
    if (state_q == LOAD) begin
      eng_input_valid   = in_valid[grant_q];
      eng_new_matrix    = in_new_matrix[grant_q];
      in_ready[grant_q] = eng_input_ready;
    end
    if (state_q == DRAIN) begin
      out_valid[grant_q] = eng_output_valid;
      eng_output_ready   = out_ready[grant_q];
    end
  end

  assign in_acc    = eng_input_valid & eng_input_ready;
  assign out_acc   = eng_output_valid & eng_output_ready;
  assign out_data  = eng_output_data;
  assign eng_rst   = ~reset;
  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign mat_owner = mat_owner_q;

  // The job length is decided by the flag on the first word, so use it live then.
  assign len_cur = (cnt_q == 7'd0) ? (in_new_matrix[grant_q] ? LEN_MAT : LEN_VEC) : len_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    mat_owner_d  = mat_owner_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = gnt_idx;
          cnt_d   = 7'd0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_acc) begin
          len_d = len_cur;
          if (cnt_q == 7'd0 && in_new_matrix[grant_q]) begin
            mat_owner_d = grant_q ? MAT_C1 : MAT_C0;
          end
          if (cnt_q == len_cur - 7'd1) begin
            cnt_d   = 7'd0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      DRAIN: begin
        if (out_acc) begin
          if (cnt_q == LAST_RES) begin
            cnt_d        = 7'd0;
            last_grant_d = grant_q;
            state_d      = IDLE;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mat_owner_q  <= MAT_NONE;
      cnt_q        <= 7'd0;
      len_q        <= 7'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      mat_owner_q  <= mat_owner_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
    end
  end

endmodule

// File: tb/tb_mvm_job_arbiter.sv
// tb/tb_mvm_job_arbiter.sv - table-driven and randomized checks of mvm_job_arbiter
module tb_mvm_job_arbiter;
  import mvm_arb_pkg::*;

  localparam int W = 12;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     in_valid, in_ready, in_new_matrix, out_valid, out_ready, mat_owner;
  logic [2*W-1:0] in_data, out_data, eng_output_data;
  logic [W-1:0]   eng_input_data;
  logic           eng_rst, eng_input_valid, eng_input_ready, eng_new_matrix;
  logic           eng_output_valid, eng_output_ready, grant, busy;

  always #5 clk = ~clk;

  mvm_job_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .in_new_matrix    (in_new_matrix),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .eng_rst          (eng_rst),
    .eng_input_valid  (eng_input_valid),
    .eng_input_ready  (eng_input_ready),
    .eng_input_data   (eng_input_data),
    .eng_new_matrix   (eng_new_matrix),
    .eng_output_valid (eng_output_valid),
    .eng_output_ready (eng_output_ready),
    .eng_output_data  (eng_output_data),
    .grant            (grant),
    .busy             (busy),
    .mat_owner        (mat_owner)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Job-level model: client word queues, an engine that answers after a full job,
  // and the round-robin/ownership rules tracked per job.
  logic [W-1:0]   wq0[$];
  logic [W-1:0]   wq1[$];
  logic [2*W-1:0] res_q[$];
  logic [1:0]     nm_job = 2'b00;
  int cur_owner = -1, last_served = 1, mat_model = 0, res_cnt = 0;
  int first_served = -1, drain_hold = 0, eng_cnt = 0, eng_len = 0, out_mode = 0;
  bit idle_chk = 1'b0, in_rnd = 1'b0;

  task automatic add_job(input int c, input logic nm);
    int n;
    n = nm ? JOB_WORDS_MAT : JOB_WORDS_VEC;
    nm_job[c] = nm;
    for (int i = 0; i < n; i++) begin
      if (c == 1) wq1.push_back(W'($urandom));
      else        wq0.push_back(W'($urandom));
    end
  endtask

  task automatic step;
    logic [1:0] acc;
    logic       hs;
    int         expw;
    @(negedge clk);
    in_valid[0]      = (wq0.size() > 0);
    in_valid[1]      = (wq1.size() > 0);
    in_data          = {(wq1.size() > 0) ? wq1[0] : W'(0), (wq0.size() > 0) ? wq0[0] : W'(0)};
    in_new_matrix    = nm_job;
    eng_input_ready  = in_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    eng_output_valid = (res_q.size() > 0) && (!in_rnd || $urandom_range(0, 3) != 0);
    eng_output_data  = (res_q.size() > 0) ? res_q[0] : '0;
    for (int c = 0; c < 2; c++) begin
      case (out_mode)
        0:       out_ready[c] = 1'b1;
        1:       out_ready[c] = 1'($urandom_range(0, 1));
        default: out_ready[c] = (drain_hold == 0);
      endcase
    end
    #1;
    if (idle_chk) begin
      chk("busy_after_release", int'(busy), 0);
      chk("in_ready_after_release", int'(in_ready), 0);
      chk("mat_owner", int'(mat_owner), mat_model);
      idle_chk = 1'b0;
    end

    acc = in_valid & in_ready;
    hs  = eng_input_valid & eng_input_ready;
    if (acc != 2'b00 || hs) chk("in_handshake_match", int'(acc != 2'b00), int'(hs));
    for (int c = 0; c < 2; c++) begin
      if (acc[c]) begin
        if (cur_owner < 0) begin
          expw = (&in_valid) ? 1 - last_served : (in_valid[1] ? 1 : 0);
          chk("grant_pick", c, expw);
          chk("grant_out", int'(grant), c);
          chk("busy_on", int'(busy), 1);
          chk("eng_new_matrix", int'(eng_new_matrix), int'(nm_job[c]));
          if (first_served < 0) first_served = c;
          cur_owner  = c;
          res_cnt    = 0;
          drain_hold = 5;
          if (nm_job[c]) mat_model = c + 1;
        end else begin
          chk("word_owner", c, cur_owner);
        end
        if (c == 1) begin
          chk("eng_data", int'(eng_input_data), int'(wq1[0]));
          void'(wq1.pop_front());
        end else begin
          chk("eng_data", int'(eng_input_data), int'(wq0[0]));
          void'(wq0.pop_front());
        end
      end
    end
    if (hs) begin
      if (eng_cnt == 0) eng_len = eng_new_matrix ? JOB_WORDS_MAT : JOB_WORDS_VEC;
      eng_cnt++;
      if (eng_cnt == eng_len) begin
        eng_cnt = 0;
        for (int k = 0; k < NUM_RESULTS; k++) res_q.push_back((2*W)'($urandom));
      end
    end

    for (int c = 0; c < 2; c++) begin
      if (out_valid[c]) chk("out_valid_owner", c, cur_owner);
    end
    if (cur_owner >= 0 && eng_output_valid &&
        ((cur_owner == 0 && wq0.size() == 0) || (cur_owner == 1 && wq1.size() == 0)))
      chk("out_valid_pass", int'(out_valid[cur_owner]), 1);
    acc = out_valid & out_ready;
    hs  = eng_output_valid & eng_output_ready;
    if (acc != 2'b00 || hs) chk("out_handshake_match", int'(acc != 2'b00), int'(hs));
    if (acc != 2'b00 && cur_owner >= 0 && res_q.size() > 0) begin
      chk("out_data", int'(out_data), int'(res_q[0]));
      res_cnt++;
      if (res_cnt == NUM_RESULTS) begin
        last_served = cur_owner;
        cur_owner   = -1;
        idle_chk    = 1'b1;
      end
    end
    if (hs && res_q.size() > 0) void'(res_q.pop_front());
    if (out_mode == 2 && eng_output_valid && drain_hold > 0) drain_hold--;
  endtask

  task automatic run_round(input logic [1:0] req, input logic [1:0] nm, output int first);
    int cyc;
    cyc = 0;
    first_served = -1;
    for (int c = 0; c < 2; c++) if (req[c]) add_job(c, nm[c]);
    while ((wq0.size() > 0 || wq1.size() > 0 || cur_owner >= 0 || idle_chk) && cyc < 3000) begin
      step();
      cyc++;
    end
    chk("round_in_budget", int'(cyc < 3000), 1);
    first = first_served;
  endtask

  typedef struct {
    logic [1:0] req;
    logic [1:0] nm;
    int         exp_first;
    int         exp_owner;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int first;
    int cyc;
    tbl[0] = '{2'b11, 2'b00, 0, 0};
    tbl[1] = '{2'b11, 2'b00, 0, 0};
    tbl[2] = '{2'b01, 2'b01, 0, 1};
    tbl[3] = '{2'b11, 2'b00, 1, 1};
    tbl[4] = '{2'b10, 2'b00, 1, 1};
    tbl[5] = '{2'b11, 2'b10, 0, 2};
    tbl[6] = '{2'b11, 2'b01, 0, 1};

    reset = 1'b0;
    in_valid = 2'b00; in_data = '0; in_new_matrix = 2'b00; out_ready = 2'b00;
    eng_input_ready = 1'b1; eng_output_valid = 1'b0; eng_output_data = '0;
    repeat (2) @(negedge clk);
    in_valid = 2'b11;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_mat_owner", int'(mat_owner), 0);
    chk("rst_eng_rst", int'(eng_rst), 1);
    chk("rst_eng_input_valid", int'(eng_input_valid), 0);
    in_valid = 2'b00;
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_round(tbl[i].req, tbl[i].nm, first);
      chk("tbl_first", first, tbl[i].exp_first);
      chk("tbl_owner", int'(mat_owner), tbl[i].exp_owner);
    end

    in_rnd = 1'b1;
    out_mode = 1;
    for (int i = 0; i < 6; i++) begin
      run_round(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), first);
    end

    out_mode = 2;
    run_round(2'b10, 2'b00, first);
    chk("hold_round_first", first, 1);

    // Reset in the middle of a matrix load, after 30 words have gone through.
    in_rnd = 1'b0;
    out_mode = 0;
    add_job(0, 1'b1);
    cyc = 0;
    while (wq0.size() > JOB_WORDS_MAT - 30 && cyc < 500) begin
      step();
      cyc++;
    end
    chk("words_before_reset", wq0.size(), JOB_WORDS_MAT - 30);
    chk("owner_before_reset", int'(mat_owner), 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    chk("mid_rst_eng_input_valid", int'(eng_input_valid), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_eng_output_ready", int'(eng_output_ready), 0);
    chk("mid_rst_mat_owner", int'(mat_owner), 0);
    chk("mid_rst_eng_rst", int'(eng_rst), 1);
    wq0.delete(); wq1.delete(); res_q.delete();
    eng_cnt = 0; cur_owner = -1; last_served = 1; mat_model = 0; idle_chk = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_round(2'b11, 2'b00, first);
    chk("post_reset_first", first, 0);
    chk("post_reset_owner", int'(mat_owner), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
